// File: rtl/ddc_sequencer_if.sv
// ddc_sequencer_if: control/status bundle between a run controller and the DDC sequencer.
// Latency: none, wires only.
// Backpressure: none; start/stop are single-cycle requests, the sequencer drops those it cannot honour.
interface ddc_sequencer_if #(
    parameter int DECIM_MAX = 32,
    parameter int PHASE_W   = 16,
    parameter int LUT_AW    = 4
);
    localparam int DW = $clog2(DECIM_MAX + 1);

    logic               start;
    logic               stop;
    logic [DW-1:0]      decim_cfg;
    logic [PHASE_W-1:0] phase_inc;
    logic               busy;
    logic               done;
    logic               err;
    logic               mixer_en;
    logic               lpf_en;
    logic               lpf_zero_in;
    logic [LUT_AW-1:0]  lo_addr;
    logic               ds_strobe;
    logic [31:0]        sample_cnt;

    // run controller side
    modport master (
        output start, stop, decim_cfg, phase_inc,
        input  busy, done, err, mixer_en, lpf_en, lpf_zero_in, lo_addr, ds_strobe, sample_cnt
    );

    // sequencer side
    modport slave (
        input  start, stop, decim_cfg, phase_inc,
        output busy, done, err, mixer_en, lpf_en, lpf_zero_in, lo_addr, ds_strobe, sample_cnt
    );
endinterface

// File: rtl/ddc_sequencer.sv
// ddc_sequencer: sequences mixer -> LPF -> decimator (flush, warm-up, run, drain) and drives the LO LUT address.
// Latency: start sampled at an edge takes effect from the next cycle; outputs decode registered state only.
// Backpressure: none; start ignored while busy, stop honoured in FLUSH/WARM/RUN. Macro DDC_SAMPLE_CNT_EN adds the strobe counter.
module ddc_sequencer #(
    parameter int DECIM_MAX = 32,
    parameter int PHASE_W   = 16,
    parameter int LUT_AW    = 4,
    parameter int FLUSH_LEN = 64,
    parameter int MIX_LAT   = 2,
    parameter int LPF_LAT   = 8
) (
    input logic            clk,
    input logic            reset,
    ddc_sequencer_if.slave bus
);
    localparam int DW       = $clog2(DECIM_MAX + 1);
    localparam int PIPE_LAT = MIX_LAT + LPF_LAT;
    localparam int CMAX     = (FLUSH_LEN > PIPE_LAT) ? FLUSH_LEN : PIPE_LAT;
    localparam int CW       = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        WARM  = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      phase_cnt;   // cycles already spent in FLUSH/WARM/DRAIN
    logic [DW-1:0]      decim;
    logic [DW-1:0]      dcnt;
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] inc;
    logic               cfg_ok;
    logic               start_ok;
    logic               phase_last;
    logic               done_q;
    logic               err_q;

    logic               busy;
    logic               mixer_en;
    logic               lpf_en;
    logic               lpf_zero_in;
    logic               ds_strobe;

    assign cfg_ok   = (bus.decim_cfg >= DW'(2)) && (bus.decim_cfg <= DW'(DECIM_MAX));
    assign start_ok = (state == IDLE) && bus.start && cfg_ok;

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state: stop aborts FLUSH/WARM, turns RUN into DRAIN, and is ignored in IDLE/DRAIN
    always_comb begin
        state_nxt  = state;
        phase_last = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok) state_nxt = FLUSH;
            end
            FLUSH: begin
                phase_last = (phase_cnt == CW'(FLUSH_LEN - 1));
                if (bus.stop)        state_nxt = IDLE;
                else if (phase_last) state_nxt = WARM;
            end
            WARM: begin
                phase_last = (phase_cnt == CW'(PIPE_LAT - 1));
                if (bus.stop)        state_nxt = IDLE;
                else if (phase_last) state_nxt = RUN;
            end
            RUN: begin
                if (bus.stop) state_nxt = DRAIN;
            end
            DRAIN: begin
                phase_last = (phase_cnt == CW'(PIPE_LAT - 1));
                if (phase_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // outputs decoded from the registered state; the LPF keeps clocking through flush, warm-up and drain
    always_comb begin
        busy        = (state != IDLE);
        lpf_en      = (state != IDLE);
        lpf_zero_in = (state == FLUSH);
        mixer_en    = (state == WARM) || (state == RUN) || (state == DRAIN);
        ds_strobe   = ((state == RUN) || (state == DRAIN)) && (dcnt == decim - DW'(1));
    end

    // config latch, phase accumulator, phase/decim counters and the done/err pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_cnt <= '0;
            decim     <= '0;
            inc       <= '0;
            acc       <= '0;
            dcnt      <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (state_nxt != state) begin
                phase_cnt <= '0;
            end else if ((state == FLUSH) || (state == WARM) || (state == DRAIN)) begin
                phase_cnt <= phase_cnt + CW'(1);
            end

            if (start_ok) begin
                decim <= bus.decim_cfg;
                inc   <= bus.phase_inc;
                acc   <= '0;
            end else if (mixer_en) begin
                acc <= acc + inc;
            end

            // decim phase is continuous from RUN into DRAIN; zero elsewhere so RUN always starts at 0
            if ((state == RUN) || (state == DRAIN)) begin
                dcnt <= ds_strobe ? '0 : dcnt + DW'(1);
            end else begin
                dcnt <= '0;
            end

            done_q <= (state == DRAIN) && phase_last;
            err_q  <= (state == IDLE) && bus.start && !cfg_ok;
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.mixer_en    = mixer_en;
    assign bus.lpf_en      = lpf_en;
    assign bus.lpf_zero_in = lpf_zero_in;
    assign bus.lo_addr     = acc[PHASE_W-1 -: LUT_AW];
    assign bus.ds_strobe   = ds_strobe;

`ifdef DDC_SAMPLE_CNT_EN
    logic [31:0] sample_cnt;

    // strobe counter: cleared per run, saturating, held after the run ends
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_cnt <= '0;
        end else if (start_ok) begin
            sample_cnt <= '0;
        end else if (ds_strobe && (sample_cnt != 32'hFFFF_FFFF)) begin
            sample_cnt <= sample_cnt + 32'd1;
        end
    end

    assign bus.sample_cnt = sample_cnt;
`else
    assign bus.sample_cnt = '0;
`endif

endmodule

// File: tb/tb_ddc_sequencer.sv
// tb_ddc_sequencer: scoreboard bench for ddc_sequencer; strobe/done/err cycles are queued when stimulus is driven.
// Latency: start driven in cycle k is sampled at the edge ending k; effects visible from cycle k+1.
// Backpressure: none.
module tb_ddc_sequencer;
    localparam int DW = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    int exp_strobe_q[$];
    int exp_done_q[$];
    int exp_err_q[$];

    ddc_sequencer_if #(.DECIM_MAX(32), .PHASE_W(16), .LUT_AW(4)) bus ();

    ddc_sequencer #(
        .DECIM_MAX(32), .PHASE_W(16), .LUT_AW(4),
        .FLUSH_LEN(64), .MIX_LAT(2), .LPF_LAT(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // output monitor: every strobe/done/err pops its expected cycle
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.ds_strobe) begin
                if (exp_strobe_q.size() == 0) check("strobe_unexpected", cyc, -1);
                else                          check("strobe_cycle", cyc, exp_strobe_q.pop_front());
            end
            if (bus.done) begin
                check("busy_at_done", bus.busy, 0);
                if (exp_done_q.size() == 0) check("done_unexpected", cyc, -1);
                else                        check("done_cycle", cyc, exp_done_q.pop_front());
            end
            if (bus.err) begin
                if (exp_err_q.size() == 0) check("err_unexpected", cyc, -1);
                else                       check("err_cycle", cyc, exp_err_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic queues_empty(input string tag);
        check({tag, "_strobe_left"}, exp_strobe_q.size(), 0);
        check({tag, "_done_left"}, exp_done_q.size(), 0);
        check({tag, "_err_left"}, exp_err_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_mixer_en"}, bus.mixer_en, 0);
        check({tag, "_lpf_en"}, bus.lpf_en, 0);
        check({tag, "_lpf_zero_in"}, bus.lpf_zero_in, 0);
        check({tag, "_lo_addr"}, bus.lo_addr, 0);
        check({tag, "_ds_strobe"}, bus.ds_strobe, 0);
        check({tag, "_sample_cnt"}, bus.sample_cnt, 0);
    endtask

    // full run: start now, stop on the cycle of strobe number nstr, expect drain strobes and done
    task automatic do_run(input int d, input logic [15:0] inc, input int nstr,
                          input bit detail, input bit collide, input bit stop_at_start);
        int k, first, s, r, nexp;
        logic [15:0] ph;
        longint exp_cnt;
        k = cyc;
        bus.start     = 1'b1;
        bus.stop      = stop_at_start;
        bus.decim_cfg = DW'(d);
        bus.phase_inc = inc;
        first = k + 64 + 10 + d;
        s     = first + (nstr - 1) * d;
        nexp  = 0;
        for (int t = first; t <= s + 10; t += d) begin
            exp_strobe_q.push_back(t);
            nexp++;
        end
        exp_done_q.push_back(s + 11);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.decim_cfg = DW'(3);
        bus.phase_inc = 16'h0777;
        while (cyc <= s + 11) begin
            r = cyc - k;
            if (detail) begin
                if (r == 1) begin
                    check("busy_rise", bus.busy, 1);
                    check("lpf_en_flush", bus.lpf_en, 1);
                    check("zero_in_first", bus.lpf_zero_in, 1);
                    check("mixer_flush", bus.mixer_en, 0);
                end
                if (r == 64) begin
                    check("zero_in_last", bus.lpf_zero_in, 1);
                    check("mixer_before_warm", bus.mixer_en, 0);
                end
                if (r == 65) begin
                    check("zero_in_warm", bus.lpf_zero_in, 0);
                    check("mixer_warm", bus.mixer_en, 1);
                end
                if (r >= 65 && cyc <= s + 10) begin
                    ph = 16'((r - 65) * int'(inc));
                    check("lo_addr", bus.lo_addr, ph[15:12]);
                end
            end
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            if (collide && cyc == first + d) bus.start = 1'b1;
            if (cyc == s) begin
                bus.stop = 1'b1;
                if (collide) bus.start = 1'b1;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        #1;
        check("busy_after_run", bus.busy, 0);
`ifdef DDC_SAMPLE_CNT_EN
        exp_cnt = nexp;
`else
        exp_cnt = 0;
`endif
        check("sample_cnt", bus.sample_cnt, exp_cnt);
        queues_empty("run");
    endtask

    task automatic bad_start(input int d);
        bus.start     = 1'b1;
        bus.decim_cfg = DW'(d);
        exp_err_q.push_back(cyc + 1);
        @(negedge clk);
        bus.start = 1'b0;
        check("bad_busy", bus.busy, 0);
        check("bad_lpf_en", bus.lpf_en, 0);
        check("bad_mixer_en", bus.mixer_en, 0);
        repeat (3) @(negedge clk);
        check("bad_busy_later", bus.busy, 0);
        #1;
        queues_empty("bad");
    endtask

    task automatic abort_flush();
        int k, mix_seen;
        k = cyc;
        mix_seen = 0;
        bus.start     = 1'b1;
        bus.decim_cfg = DW'(8);
        bus.phase_inc = 16'h0100;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc <= k + 130) begin
            if (bus.mixer_en) mix_seen++;
            if (cyc == k + 20) check("abort_zero_in", bus.lpf_zero_in, 1);
            if (cyc == k + 21) check("abort_busy", bus.busy, 0);
            bus.stop = (cyc == k + 20);
            @(negedge clk);
        end
        bus.stop = 1'b0;
        check("abort_mixer_seen", mix_seen, 0);
        #1;
        queues_empty("abort");
    endtask

    task automatic reset_mid_run();
        int k;
        k = cyc;
        bus.start     = 1'b1;
        bus.decim_cfg = DW'(6);
        bus.phase_inc = 16'h0C40;
        exp_strobe_q.push_back(k + 80);
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < k + 85) @(negedge clk);
        check("pre_reset_busy", bus.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("midrst");
        @(negedge clk);
        check("midrst_busy_after", bus.busy, 0);
        #1;
        queues_empty("midrst");
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.decim_cfg = '0;
        bus.phase_inc = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset");
        mon_en = 1'b1;
        @(negedge clk);

        do_run(30, 16'h1000, 3, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        bad_start(1);
        bad_start(33);
        bad_start(0);
        do_run(4, 16'h0400, 5, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        abort_flush();
        do_run(5, 16'h2345, 4, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        do_run(32, 16'h0010, 2, 1'b0, 1'b0, 1'b0);
        do_run(2, 16'hF000, 6, 1'b1, 1'b0, 1'b0);
        reset_mid_run();
        do_run(30, 16'h1000, 2, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
